// File: rtl/byte_pack_fifo.sv
// Packs a non-stallable byte stream into little-endian words and buffers them
// in a show-ahead FIFO; words that arrive while the FIFO is full are dropped and counted.
module byte_pack_fifo #(
   parameter int DATA_W         = 8,
   parameter int BYTES_PER_WORD = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_W          = 8
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [DATA_W-1:0]                  in_data,
   input  logic                               in_valid,
   input  logic                               flush,
   output logic [DATA_W*BYTES_PER_WORD-1:0]   out_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [$clog2(FIFO_DEPTH):0]        fill_level,
   output logic                               overflow,
   output logic [CNT_W-1:0]                   drop_count
);

   localparam int WORD_W = DATA_W * BYTES_PER_WORD;
   localparam int BIDX_W = $clog2(BYTES_PER_WORD);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;

   logic [BIDX_W-1:0] byte_idx;
   logic [WORD_W-1:0] partial;
   logic [WORD_W-1:0] word_next;
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level;

   logic byte_last;
   logic take;
   logic push;
   logic pop;
   logic full;
   logic accept;
   logic drop;

   assign byte_last = (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));
   assign take      = in_valid && !flush && !reset;
   assign push      = take && byte_last;
   assign out_valid = (level != '0);
   assign pop       = out_valid && out_ready && !reset;
   assign full      = (level == LVL_W'(FIFO_DEPTH));
   // A full FIFO still takes the new word when the head leaves on the same edge.
   assign accept    = push && (!full || pop);
   assign drop      = push && full && !pop;

   always_comb begin
      word_next = partial;
      word_next[byte_idx*DATA_W +: DATA_W] = in_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         byte_idx   <= '0;
         partial    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (flush) begin
            byte_idx <= '0;
            partial  <= '0;
         end else if (in_valid) begin
            if (byte_last) begin
               byte_idx <= '0;
               partial  <= '0;
            end else begin
               byte_idx <= byte_idx + BIDX_W'(1);
               partial  <= word_next;
            end
         end

         if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);

         case ({accept, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase

         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: entries are only visible once written.
   always_ff @(posedge clock) begin
      if (accept) mem[wr_ptr] <= word_next;
   end

   assign out_data   = mem[rd_ptr];
   assign fill_level = level;

endmodule

// File: doc/byte_pack_fifo.md
Name: byte_pack_fifo

Overview:
Downstream consumer of the byte-stream generator stage. That stage emits one 8-bit byte with a single-cycle valid pulse and cannot be stalled. This block packs consecutive valid bytes into 32-bit words and buffers them in a small FIFO. It presents the words on a ready/valid interface to the next stage, and it counts and flags words lost to overflow, because its input has no backpressure.

Parameters:
DATA_W, 8, input byte width
BYTES_PER_WORD, 4, bytes packed per output word (>=2)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 8, width of drop counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  DATA_W  byte from upstream generator
in_valid  input  1  in_data valid this cycle; no backpressure
flush  input  1  discard the partial word under construction
out_data  output  DATA_W*BYTES_PER_WORD  head-of-FIFO word
out_valid  output  1  FIFO not empty
out_ready  input  1  downstream accepts out_data this cycle
fill_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: at least one word dropped since reset
drop_count  output  CNT_W  number of dropped words, saturating

Behaviour:
- Interface: clock is the clock; reset is synchronous, active-high.
- Reset: the following clear on the first rising edge with reset=1:
  - byte index, partial word and FIFO pointers -> 0
  - out_valid=0, fill_level=0, overflow=0, drop_count=0
  - out_data is don't-care while out_valid=0
  - reset overrides all other inputs; a partial word in progress is lost.
- Packing:
  - Little-endian: the byte accepted at index k goes to bits [k*DATA_W +: DATA_W].
  - The byte index increments on each in_valid=1 and wraps from BYTES_PER_WORD-1 to 0.
  - Cycles with in_valid=0 hold all state; no timeout applies.
- Word completion: on the edge where the byte at index BYTES_PER_WORD-1 is accepted, the assembled word (including that byte) is pushed into the FIFO.
- Latency: out_valid rises the cycle after that edge, if the FIFO was empty (1-cycle latency).
- Flush:
  - flush=1 resets the byte index to 0 and discards the partial word.
  - flush has priority over in_valid in the same cycle; that byte is dropped and not counted.
  - FIFO contents are unaffected.
- FIFO:
  - Show-ahead: out_data is the head entry whenever out_valid=1.
  - A pop occurs on any edge with out_valid=1 and out_ready=1.
  - out_ready while empty is ignored.
- Push vs full, evaluated per edge:
  - Push with FIFO not full: accepted.
  - Push with FIFO full and a pop on the same edge: accepted; occupancy stays FIFO_DEPTH.
  - Push with FIFO full and no pop: word dropped, overflow<=1, drop_count increments. drop_count saturates at 2^CNT_W-1.
  - Packing restarts at index 0 after a drop; the next byte starts a fresh word.
- fill_level: registered occupancy, updated every edge (+1 push only, -1 pop only, unchanged for both or neither). Range 0..FIFO_DEPTH.
- Pointers: wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit or by fill_level.
- Outputs: all outputs come from registers or memory, with no combinational in->out paths. out_data is a read of the registered array at the registered read pointer.
- Ordering: words exit in arrival order. No word is duplicated or reordered.

Test Plan:
- Basic pack: reset, then bytes 0x10,0x11,0x12,0x13 with in_valid pulses 3 cycles apart, out_ready=1 -> one word 0x13121110, out_valid high for exactly 1 cycle, starting the cycle after the 4th byte; fill_level returns to 0.
- Backpressure fill: out_ready=0, feed 16 bytes 0x00..0x0F -> fill_level=4, overflow=0. Then raise out_ready -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in order.
- Overflow: out_ready=0, feed 24 bytes 0x00..0x17 -> words 5 and 6 dropped, overflow=1, drop_count=2. Draining yields only the first 4 words; overflow stays 1.
- Simultaneous push/pop at full: FIFO full, 4th byte of a word arrives on the same edge out_ready=1 -> no drop, fill_level stays 4, new word appears last in drain order.
- Flush: bytes 0xA0,0xA1, then flush with in_valid=1 (byte 0xFF), then bytes 0xB0..0xB3 -> only word 0xB3B2B1B0 is output; 0xFF does not appear.
- Mid-operation reset: 2 words queued plus 3 bytes of a partial word, assert reset 1 cycle -> out_valid=0, fill_level=0, drop_count=0. The next 4 bytes form a complete word on their own.
